// File: rtl/mean_filter_pkg.sv
// mean_filter_pkg: default filter constants and the log2 helper for parameter checks
package mean_filter_pkg;
  localparam int MEAN_N     = 16;
  localparam int MEAN_WIDTH = 8;
  localparam int MEAN_LOG2N = 4;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/mean_filter_window.sv
// mean_filter_window: N-deep circular sample buffer returning the sample about to be overwritten
module mean_filter_window
  import mean_filter_pkg::*;
#(
  parameter int N     = MEAN_N,
  parameter int WIDTH = MEAN_WIDTH,
  parameter int LOG2N = MEAN_LOG2N
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_wr,
  output logic [WIDTH-1:0] o_evict
);
  logic [WIDTH-1:0] r_buf [N];
  logic [LOG2N-1:0] r_ptr;
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) r_buf[i] <= '0;
      r_ptr <= '0;
    end else begin
      r_buf[r_ptr] <= i_wr;
      r_ptr        <= r_ptr + 1'b1;
    end
  end
  // read-before-write: the slot under the pointer is the oldest sample
  assign o_evict = r_buf[r_ptr];
endmodule

// File: rtl/mean_filter.sv
// mean_filter: running-sum boxcar mean of the last N samples; MEAN_FILTER_ROUND_EN selects round-half-up
module mean_filter
  import mean_filter_pkg::*;
#(
  parameter int N     = MEAN_N,
  parameter int WIDTH = MEAN_WIDTH,
  parameter int LOG2N = MEAN_LOG2N
) (
  output logic [WIDTH-1:0] out,
  input  logic [WIDTH-1:0] in,
  input  logic             rst,
  input  logic             clk
);
  localparam int SW = WIDTH + LOG2N;
  if (N < 2 || LOG2N != clog2(N) || (1 << LOG2N) != N) begin : g_bad_cfg
    $error("mean_filter: N must be a power of two >= 2 and LOG2N must equal log2(N)");
  end
  logic [WIDTH-1:0] w_evict;
  logic [SW-1:0]    r_sum;
  logic [SW-1:0]    w_adj;
  mean_filter_window #(.N(N), .WIDTH(WIDTH), .LOG2N(LOG2N)) u_window (
    .clk     (clk),
    .rst     (rst),
    .i_wr    (in),
    .o_evict (w_evict)
  );
  always_ff @(posedge clk) begin
    if (rst) r_sum <= '0;
    else     r_sum <= r_sum + SW'(in) - SW'(w_evict);
  end
`ifdef MEAN_FILTER_ROUND_EN
  assign w_adj = r_sum + SW'(N / 2);
`else
  assign w_adj = r_sum;
`endif
  assign out = w_adj[SW-1:LOG2N];
endmodule

// File: tb/tb_mean_filter.sv
// tb_mean_filter: directed checks of reset, fill ramp, window mean, drain, full scale and mid-run reset
module tb_mean_filter;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] din = '0;
  logic [7:0] dout;
  int total = 0;
  int bad = 0;
  logic [7:0] prev;
  logic [7:0] win [16] = '{8'd128, 8'd124, 8'd127, 8'd120, 8'd124, 8'd122, 8'd124, 8'd126,
                           8'd128, 8'd123, 8'd128, 8'd124, 8'd127, 8'd120, 8'd124, 8'd122};

  mean_filter dut (.out(dout), .in(din), .rst(rst), .clk(clk));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input logic r, input logic [7:0] v);
    rst = r;
    din = v;
    @(posedge clk);
    #1;
  endtask

  initial begin
    step(1'b1, 8'd1);
    check("reset_hold0", dout, 8'd0);
    step(1'b1, 8'd1);
    check("reset_hold1", dout, 8'd0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 8'd0);
      check("post_reset_zero", dout, 8'd0);
    end
    step(1'b1, 8'd0);
    for (int k = 1; k <= 18; k++) begin
      step(1'b0, 8'd128);
      check($sformatf("ramp%0d", k), dout, k >= 16 ? 8'd128 : 8'(8 * k));
    end
    step(1'b1, 8'd0);
    check("reset_after_ramp", dout, 8'd0);
    for (int i = 0; i < 16; i++) step(1'b0, win[i]);
    check("window_mean", dout, 8'd124);
    step(1'b1, 8'd200);
    check("midrun_reset", dout, 8'd0);
    step(1'b0, 8'd128);
    check("refill1", dout, 8'd8);
    step(1'b0, 8'd128);
    check("refill2", dout, 8'd16);
    step(1'b1, 8'd0);
    for (int i = 0; i < 16; i++) step(1'b0, win[i]);
    check("window_mean2", dout, 8'd124);
    prev = dout;
    for (int k = 1; k <= 16; k++) begin
      step(1'b0, 8'd0);
      check($sformatf("drain_mono%0d", k), {7'd0, dout <= prev}, 8'd1);
      prev = dout;
    end
    check("drain_zero", dout, 8'd0);
    step(1'b0, 8'd0);
    check("drain_hold", dout, 8'd0);
    for (int i = 0; i < 15; i++) step(1'b0, 8'd255);
    check("full_scale_fill15", {7'd0, dout < 8'd255}, 8'd1);
    step(1'b0, 8'd255);
    check("full_scale", dout, 8'd255);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 8'd255);
      check("full_scale_hold", dout, 8'd255);
    end
    step(1'b0, 8'd0);
    check("full_scale_evict", dout, 8'd239);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mean_filter.md
# mean_filter

Streaming moving-average (boxcar) filter. Every clock it accepts one unsigned sample and outputs the truncated mean of the most recent N samples. It sits in the sample datapath as a smoothing stage, with one sample per clock and no handshake. It uses a running-sum architecture: one add and one subtract per cycle, with no multi-operand adder tree.

## Interface
Parameters, in positional order:
- `N`, default 16: window length in samples; must be a power of two, ≥ 2.
- `WIDTH`, default 8: sample and output width in bits, unsigned.
- `LOG2N`, default 4: log2(N); must equal log2(N), elaboration error otherwise.

Ports (positional instantiation order is `out, in, rst, clk`):
- `clk`  in  1  Sole clock; all state updates on the rising edge.
- `rst`  in  1  Reset is synchronous and active-high.
- `in`   in  `WIDTH`  Input sample, captured every rising edge while `rst` = 0.
- `out`  out  `WIDTH`  Window mean, registered.

## Operation
- Window buffer: N × `WIDTH` circular buffer, initially all zero.
- Write pointer: `LOG2N` bits, wraps naturally from N−1 to 0.
- Accumulator `sum`: `WIDTH`+`LOG2N` bits, unsigned. This width cannot overflow, since the maximum is (2^`WIDTH`−1)·N.
- Each non-reset edge:
  - `sum` ← `sum` + `in` − `buf[ptr]`
  - `buf[ptr]` ← `in`
  - `ptr` ← `ptr`+1
- `out` = `sum` >> `LOG2N`, taken from the registered `sum`. The default is truncation (floor).
- Reset edge:
  - All buffer entries, `sum` and `ptr` go to 0.
  - `in` is ignored.
- Reset value of `out` is 0.
- Startup and fill: before N samples have been taken, missing samples count as zero. There is no valid flag; the output ramps up during fill.
- Reset mid-operation: the window is discarded entirely. The next N samples refill from zero, exactly as at power-up.
- `sum` must always equal the exact sum of the buffer contents. There is no drift, so no periodic re-sum is needed.

## Timing
- Latency: a sample captured at edge k contributes to `out` immediately after edge k.
- `out` after edge k = floor((x_k + … + x_{k−N+1}) / N).
- Throughput: one sample per cycle, sustained indefinitely.
- Step response: a constant input step reaches its final value N edges after the step.
- `rst` asserted on edge k: `out` = 0 after edge k. The first sample after reset is the one present on the first edge with `rst` = 0.
- No combinational path from `in` to `out`.

## Configuration
- `MEAN_FILTER_ROUND_EN` defined:
  - `out` = (`sum` + N/2) >> `LOG2N`, i.e. round-half-up.
  - The add happens at the accumulator width and cannot overflow, since (2^`WIDTH`−1)·N + N/2 < 2^(`WIDTH`+`LOG2N`).
- `MEAN_FILTER_ROUND_EN` undefined: plain truncation.
- Both variants have identical latency and reset behaviour.

## Structure
- Package `mean_filter_pkg` holds:
  - default constants `MEAN_N`, `MEAN_WIDTH`, `MEAN_LOG2N`;
  - a function `clog2`-style check used for the N/`LOG2N` consistency assertion.
- Sub-module `mean_filter_window`: the N-deep circular sample buffer with write pointer. It returns the sample being evicted (read-before-write at the same address) and holds its own synchronous clear.
- Top level keeps the accumulator, the output shift and the rounding option.

## Test plan
- Reset hold: `rst` = 1 for 2 edges with `in` = 1 → `out` = 0 throughout. The buffer stays empty; after release with `in` = 0, `out` stays 0.
- Fill ramp: after reset, `in` = 128 constant → `out` = 8, 16, …, 120, then 128 from the 16th edge onward.
- Window mean: after reset, feed 128,124,127,120,124,122,124,126,128,123,128,124,127,120,124,122. After the 16th sample, sum = 1991 → `out` = 124 truncated; with `MEAN_FILTER_ROUND_EN` also 124, since 1999>>4 = 124.
- Drain: following that window, feed `in` = 0 → `out` decreases monotonically and reaches exactly 0 after the 16th zero, then holds 0.
- Full scale: 16 samples of 255 → `out` = 255 in both variants, with no accumulator wrap.
- Mid-run reset: assert `rst` for 1 edge while `out` = 124 → `out` = 0 next cycle. Refill with 128 reproduces the ramp from 8.
